// File: rtl/uart_rx_debug.sv
// UART receiver, 8N1, LSB first, idle-high line.
// Pairs with the UART debug transmitter. The serial input is double-flopped before any
// decision is made. The start bit is re-checked at mid-bit. Each data bit and the stop bit
// are sampled one bit time apart from that point.
// A good byte lands in a holding register with a ready/ack handshake.
// Framing errors and overruns are reported as single-cycle pulses.
// The state register is brought out for ILA probing.

module uart_rx_debug #(
    parameter int unsigned CLKS_PER_BIT = 868,
    // Mid-bit sample offset; derived, not meant to be overridden.
    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_Serial,
    input  logic       Read_Ack,
    output logic [7:0] Rx_Parallel,
    output logic       Rx_Ready,
    output logic       Framing_Error,
    output logic       Overrun,
    output logic [2:0] SM
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CntHalf = CW'(HALF_BIT);
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitIdle = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q;
    logic          rx_s_q;
    logic [CW-1:0] clk_count_q, clk_count_d;
    logic [2:0]    bit_index_q, bit_index_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= Rx_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, bit timing, sampling and handshake logic.
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = ready_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consumer acknowledge; a load in the same cycle overrides this below.
        if (Read_Ack && ready_q) begin
            ready_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                clk_count_d = '0;
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (clk_count_q == CntHalf) begin
                    clk_count_d = '0;
                    // A line that is high again at mid-bit was a glitch, not a start bit.
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end

            StData: begin
                if (clk_count_q == CntLast) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rx_s_q;
                    if (bit_index_q != 3'd7) begin
                        bit_index_d = bit_index_q + 3'd1;
                    end else begin
                        bit_index_d = '0;
                        state_d     = StStop;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end

            StStop: begin
                if (clk_count_q == CntLast) begin
                    clk_count_d = '0;
                    if (rx_s_q) begin
                        data_d    = shift_q;
                        ready_d   = 1'b1;
                        // Overrun only if the old byte is still unclaimed at load time.
                        overrun_d = ready_q && !Read_Ack;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end

            // Hold off until the line goes high so a break is reported only once.
            StWaitIdle: begin
                clk_count_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d     = StIdle;
                clk_count_d = '0;
                bit_index_d = '0;
            end
        endcase
    end

    assign Rx_Parallel   = data_q;
    assign Rx_Ready      = ready_q;
    assign Framing_Error = frame_err_q;
    assign Overrun       = overrun_q;
    assign SM            = state_q;

endmodule

// File: tb/tb_uart_rx_debug.sv
// Self-checking bench for uart_rx_debug at 16 clocks per bit.
// A transmitter task drives frames on the line.
// A frame-level reference model predicts the byte, ready, overrun and framing results.

module tb_uart_rx_debug;

    localparam int CPB = 16;
    // Negedges from start-bit drive to the cycle whose closing edge samples the stop bit.
    localparam int LOAD_EDGE = 3 + (CPB - 1) / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       read_ack = 1'b0;
    logic [7:0] rx_parallel;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun;
    logic [2:0] sm;

    always #5 clk = ~clk;

    uart_rx_debug #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .Rx_Serial    (rx_line),
        .Read_Ack     (read_ack),
        .Rx_Parallel  (rx_parallel),
        .Rx_Ready     (rx_ready),
        .Framing_Error(framing_error),
        .Overrun      (overrun),
        .SM           (sm)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by the monitor.
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         wide_cnt = 0;
    int         stop_idle_cnt = 0;
    logic       prev_ready = 1'b0;
    logic       prev_fe = 1'b0;
    logic       prev_ov = 1'b0;
    logic [2:0] prev_sm = 3'd0;
    logic [7:0] rise_q[$];
    logic [2:0] sm_hist[$];

    // Reference model state.
    logic [7:0] m_data = 8'h00;
    bit         m_ready = 1'b0;
    int         m_fe = 0;
    int         m_ov = 0;
    logic [7:0] exp_rise[$];

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_ready = 1'b0;
            prev_fe    = 1'b0;
            prev_ov    = 1'b0;
            prev_sm    = 3'd0;
        end else begin
            if (rx_ready && !prev_ready) rise_q.push_back(rx_parallel);
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if ((framing_error && prev_fe) || (overrun && prev_ov)) wide_cnt++;
            if (sm !== prev_sm) begin
                sm_hist.push_back(sm);
                if (prev_sm == 3'd3 && sm == 3'd0) stop_idle_cnt++;
            end
            prev_ready = rx_ready;
            prev_fe    = framing_error;
            prev_ov    = overrun;
            prev_sm    = sm;
        end
    end

    // Frame-level outcome: a good stop bit loads the byte, a bad one only flags.
    function automatic void model_frame(input logic [7:0] b, input bit stop, input bit ack_at_load);
        if (stop) begin
            if (m_ready && !ack_at_load) m_ov++;
            if (!m_ready) exp_rise.push_back(b);
            m_data  = b;
            m_ready = 1'b1;
        end else begin
            m_fe++;
            if (ack_at_load) m_ready = 1'b0;
        end
    endfunction

    function automatic void model_ack();
        m_ready = 1'b0;
    endfunction

    // Transmitter: start bit, 8 data bits LSB first, stop bit; call on a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Same frame, with Read_Ack high during the stop-sample cycle.
    task automatic send_frame_ack(input logic [7:0] b, input logic stop_bit);
        fork
            send_frame(b, stop_bit);
            begin
                repeat (LOAD_EDGE) @(negedge clk);
                read_ack = 1'b1;
                @(negedge clk);
                read_ack = 1'b0;
            end
        join
    endtask

    task automatic do_ack();
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
    endtask

    task automatic check_rise(input string name);
        n_checks++;
        if (rise_q.size() != exp_rise.size()) begin
            n_fail++;
            $display("FAIL %s_rise_count: got %0d expected %0d", name, rise_q.size(),
                     exp_rise.size());
        end else begin
            foreach (exp_rise[i]) begin
                n_checks++;
                if (rise_q[i] !== exp_rise[i]) begin
                    n_fail++;
                    $display("FAIL %s_rise_byte%0d: got %h expected %h", name, i, rise_q[i],
                             exp_rise[i]);
                end
            end
        end
        rise_q.delete();
        exp_rise.delete();
    endtask

    task automatic check_outcome(input string name);
        n_checks++;
        if (rx_parallel !== m_data) begin
            n_fail++;
            $display("FAIL %s_data: got %h expected %h", name, rx_parallel, m_data);
        end
        n_checks++;
        if (rx_ready !== m_ready) begin
            n_fail++;
            $display("FAIL %s_ready: got %b expected %b", name, rx_ready, m_ready);
        end
        n_checks++;
        if (fe_cnt != m_fe) begin
            n_fail++;
            $display("FAIL %s_framing_count: got %0d expected %0d", name, fe_cnt, m_fe);
        end
        n_checks++;
        if (ov_cnt != m_ov) begin
            n_fail++;
            $display("FAIL %s_overrun_count: got %0d expected %0d", name, ov_cnt, m_ov);
        end
        n_checks++;
        if (wide_cnt != 0) begin
            n_fail++;
            $display("FAIL %s_pulse_width: got %0d wide pulses expected 0", name, wide_cnt);
        end
        check_rise(name);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sm !== 3'd0 || rx_parallel !== 8'h00 || rx_ready !== 1'b0 ||
            framing_error !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sm=%0d data=%h rdy=%b fe=%b ov=%b expected all 0",
                     sm, rx_parallel, rx_ready, framing_error, overrun);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (sm !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got sm=%0d expected 0", sm);
        end
    endtask

    task automatic test_single_byte();
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_outcome("single");
        do_ack();
        model_ack();
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack_clears: got %b expected 0", rx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3];
        int         base_idle;
        bytes[0]  = 8'h00;
        bytes[1]  = 8'hFF;
        bytes[2]  = 8'h3C;
        base_idle = stop_idle_cnt;
        fork
            for (int k = 0; k < 3; k++) send_frame(bytes[k], 1'b1);
            for (int k = 0; k < 3; k++) begin
                repeat (k == 0 ? LOAD_EDGE + 2 : 10 * CPB - 1) @(negedge clk);
                read_ack = 1'b1;
                @(negedge clk);
                read_ack = 1'b0;
            end
        join
        for (int k = 0; k < 3; k++) begin
            model_frame(bytes[k], 1'b1, 1'b0);
            model_ack();
        end
        repeat (4) @(negedge clk);
        check_outcome("b2b");
        n_checks++;
        if (stop_idle_cnt - base_idle != 3) begin
            n_fail++;
            $display("FAIL b2b_stop_to_idle: got %0d expected 3", stop_idle_cnt - base_idle);
        end
    endtask

    task automatic test_false_start();
        sm_hist.delete();
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (sm_hist.size() != 2 || sm_hist[0] !== 3'd1 || sm_hist[1] !== 3'd0) begin
            n_fail++;
            $display("FAIL false_start_sm: got %0d transitions expected START then IDLE",
                     sm_hist.size());
        end
        check_outcome("false_start");
    endtask

    task automatic test_framing();
        send_frame(8'h6E, 1'b1);
        model_frame(8'h6E, 1'b1, 1'b0);
        sm_hist.delete();
        send_frame(8'h55, 1'b0);
        model_frame(8'h55, 1'b0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        n_checks++;
        if (sm !== 3'd4) begin
            n_fail++;
            $display("FAIL framing_wait_idle: got sm=%0d expected 4", sm);
        end
        rx_line = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (sm_hist.size() != 5 || sm_hist[0] !== 3'd1 || sm_hist[1] !== 3'd2 ||
            sm_hist[2] !== 3'd3 || sm_hist[3] !== 3'd4 || sm_hist[4] !== 3'd0) begin
            n_fail++;
            $display("FAIL framing_sm_path: got %0d transitions expected 1,2,3,4,0",
                     sm_hist.size());
        end
        check_outcome("framing");
        do_ack();
        model_ack();
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_outcome("after_framing");
    endtask

    task automatic test_overrun();
        do_ack();
        model_ack();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_outcome("overrun");
        do_ack();
        model_ack();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame_ack(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_outcome("ack_at_load");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h99;
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_line = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (sm !== 3'd0 || rx_parallel !== 8'h00 || rx_ready !== 1'b0 ||
            framing_error !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got sm=%0d data=%h rdy=%b fe=%b ov=%b expected 0",
                     sm, rx_parallel, rx_ready, framing_error, overrun);
        end
        m_data  = 8'h00;
        m_ready = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_outcome("post_reset_idle");
        send_frame(8'h99, 1'b1);
        model_frame(8'h99, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_outcome("post_reset_rx");
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         stop;
        int         mode;
        for (int it = 0; it < 10; it++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            mode = int'($urandom_range(0, 2));
            if (mode == 2) send_frame_ack(b, stop);
            else send_frame(b, stop);
            model_frame(b, stop, mode == 2);
            if (!stop) begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                rx_line = 1'b1;
                repeat (2) @(negedge clk);
            end
            n_checks++;
            if (rx_parallel !== m_data || rx_ready !== m_ready) begin
                n_fail++;
                $display("FAIL random_frame%0d: got data=%h rdy=%b expected data=%h rdy=%b",
                         it, rx_parallel, rx_ready, m_data, m_ready);
            end
            if (mode == 1) begin
                do_ack();
                model_ack();
            end
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_outcome("random");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_false_start();
        test_framing();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
